// File: rtl/fifo_rd_ctrl.sv
// Burst read controller: drains burst_len words from a FIFO and presents them downstream
// with a valid/ready handshake. Define RD_CTRL_PARITY_EN to add the registered m_parity output.
module fifo_rd_ctrl #(
  parameter int DATA_W = 4,
  parameter int LEN_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              done,
  output logic [2:0]        state_dbg
`ifdef RD_CTRL_PARITY_EN
  ,
  output logic              m_parity
`endif
);

  // Handshake: a word transfers on a rising edge where m_valid && m_ready; m_data and
  // m_valid hold steady until then, and m_ready has no effect while m_valid is low.

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    WAIT    = 3'd2,
    PRESENT = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1) << (LEN_W - 1);

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] count;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] count_inc;
  logic             xfer;

  assign count_inc = count + LEN_W'(1);
  assign xfer      = m_valid && m_ready;
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    busy       = (state != IDLE);
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        // Strobe only when data exists; an empty FIFO stalls here.
        fifo_rd_en = !fifo_empty;
        if (!fifo_empty) state_nxt = WAIT;
      end
      WAIT: begin
        state_nxt = PRESENT;
      end
      PRESENT: begin
        if (xfer) state_nxt = (count_inc == len) ? DONE : FETCH;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      len     <= '0;
      m_data  <= '0;
      m_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len   <= (burst_len == '0) ? MAX_LEN : burst_len;
            count <= '0;
          end
        end
        WAIT: begin
          // FIFO read data is valid the cycle after the strobe, i.e. now.
          m_data  <= fifo_dout;
          m_valid <= 1'b1;
        end
        PRESENT: begin
          if (xfer) begin
            count   <= count_inc;
            m_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RD_CTRL_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_parity <= 1'b0;
    end else if (state == WAIT) begin
      m_parity <= ^fifo_dout;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl: table of burst vectors against a FIFO model and
// scoreboard, plus hand sequences for empty stall, back-pressure and mid-burst reset.
module tb_fifo_rd_ctrl;
  localparam int DATA_W = 4;
  localparam int LEN_W  = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  burst_len = '0;
  logic [DATA_W-1:0] fifo_dout = '0;
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready = 1'b1;
  logic              busy;
  logic              done;
  logic [2:0]        state_dbg;
`ifdef RD_CTRL_PARITY_EN
  logic              m_parity;
`endif

  fifo_rd_ctrl #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .burst_len  (burst_len),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .busy       (busy),
    .done       (done),
    .state_dbg  (state_dbg)
`ifdef RD_CTRL_PARITY_EN
    ,
    .m_parity   (m_parity)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  // FIFO model: registered read data, pointers wrap at 256
  logic [DATA_W-1:0] mem [0:255];
  logic [7:0]        wr_ptr = '0;
  logic [7:0]        rd_ptr = '0;
  logic              fifo_flush = 1'b0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_flush) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rd_en) begin
      fifo_dout <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 8'd1;
    end
  end

  // Scoreboard
  logic [DATA_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_hs = -10;
  int rd_cnt = 0;
  int done_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      cyc++;
      check("rd_en_while_empty", int'(fifo_rd_en && fifo_empty), 0);
      if (fifo_rd_en) rd_cnt++;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 1, 0);
        end else begin
          check("m_data", int'(m_data), int'(exp_q.pop_front()));
        end
        last_hs = cyc;
      end
      if (done) begin
        done_cnt++;
        check("done_after_last_hs", cyc - last_hs, 1);
      end
`ifdef RD_CTRL_PARITY_EN
      if (m_valid) check("m_parity", int'(m_parity), int'(^m_data));
`endif
    end
  end

  // Driver tasks
  task automatic push(input logic [DATA_W-1:0] v);
    mem[wr_ptr] = v;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic flush();
    @(posedge clk) #1 fifo_flush = 1'b1;
    @(posedge clk) #1 fifo_flush = 1'b0;
  endtask

  function automatic int fifo_level();
    logic [7:0] d;
    d = wr_ptr - rd_ptr;
    return int'(d);
  endfunction

  task automatic pulse_start(input int l);
    @(posedge clk) #1;
    start = 1'b1;
    burst_len = LEN_W'(l);
    @(posedge clk) #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (!m_valid && n < budget) begin
      @(posedge clk) #1;
      n++;
    end
    if (!m_valid) check("wait_valid_timeout", 0, 1);
  endtask

  task automatic wait_done(input int budget);
    int base;
    int n;
    base = done_cnt;
    n = 0;
    while (done_cnt == base && n < budget) begin
      @(posedge clk) #1;
      n++;
    end
    if (done_cnt == base) begin
      check("wait_done_timeout", 0, 1);
    end else begin
      check("done_one_cycle", int'(done), 0);
      check("busy_after_done", int'(busy), 0);
    end
  endtask

  typedef struct {
    int len_in;
    int preload;
    int exp_words;
    int exp_left;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int n;
    int rd0;
    int dn0;

    vecs[0] = '{len_in: 4,  preload: 16, exp_words: 4,  exp_left: 12};
    vecs[1] = '{len_in: 0,  preload: 16, exp_words: 16, exp_left: 0};
    vecs[2] = '{len_in: 1,  preload: 3,  exp_words: 1,  exp_left: 2};
    vecs[3] = '{len_in: 3,  preload: 3,  exp_words: 3,  exp_left: 0};
    vecs[4] = '{len_in: 16, preload: 16, exp_words: 16, exp_left: 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_en", int'(fifo_rd_en), 0);
    check("rst_m_data", int'(m_data), 0);
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    @(negedge clk) rst = 1'b0;

    // Table-driven bursts
    for (int v = 0; v < 5; v++) begin
      flush();
      for (int i = 0; i < vecs[v].preload; i++) push(DATA_W'(i));
      for (int i = 0; i < vecs[v].exp_words; i++) exp_q.push_back(DATA_W'(i));
      rd0 = rd_cnt;
      dn0 = done_cnt;
      pulse_start(vecs[v].len_in);
      check("busy_in_burst", int'(busy), 1);
      wait_valid(20, n);
      check("start_to_valid_latency", n + 1, 3);
      wait_done(200);
      check("words_left_in_queue", exp_q.size(), 0);
      check("rd_en_pulses", rd_cnt - rd0, vecs[v].exp_words);
      check("done_pulses", done_cnt - dn0, 1);
      check("fifo_level_after", fifo_level(), vecs[v].exp_left);
      exp_q.delete();
    end

    // FIFO empty at start, one word arrives 5 cycles later
    flush();
    exp_q.push_back(4'hA);
    rd0 = rd_cnt;
    pulse_start(1);
    repeat (5) begin
      @(posedge clk) #1;
      check("stall_rd_en", int'(fifo_rd_en), 0);
      check("stall_busy", int'(busy), 1);
      check("stall_m_valid", int'(m_valid), 0);
    end
    push(4'hA);
    wait_done(50);
    check("empty_seq_words_left", exp_q.size(), 0);
    check("empty_seq_rd_pulses", rd_cnt - rd0, 1);

    // Back-pressure: m_ready low 6 cycles; stray start and burst_len change ignored
    flush();
    push(4'h9);
    push(4'h3);
    exp_q.push_back(4'h9);
    exp_q.push_back(4'h3);
    m_ready = 1'b0;
    dn0 = done_cnt;
    pulse_start(2);
    wait_valid(20, n);
    rd0 = rd_cnt;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        start = 1'b1;
        burst_len = LEN_W'(1);
      end else begin
        start = 1'b0;
      end
      @(posedge clk) #1;
      check("hold_m_valid", int'(m_valid), 1);
      check("hold_m_data", int'(m_data), 9);
    end
    start = 1'b0;
    check("hold_no_rd_en", rd_cnt - rd0, 0);
    m_ready = 1'b1;
    wait_done(50);
    check("hold_words_left", exp_q.size(), 0);
    check("hold_done_pulses", done_cnt - dn0, 1);

    // Async reset in PRESENT of an 8-word burst; the already-read word is discarded
    flush();
    for (int i = 0; i < 8; i++) push(DATA_W'(i));
    m_ready = 1'b0;
    pulse_start(8);
    wait_valid(20, n);
    check("pre_rst_m_valid", int'(m_valid), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_m_valid", int'(m_valid), 0);
    check("async_rst_m_data", int'(m_data), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_done", int'(done), 0);
    check("async_rst_rd_en", int'(fifo_rd_en), 0);
    @(negedge clk) rst = 1'b0;
    m_ready = 1'b1;
    exp_q.delete();
    exp_q.push_back(DATA_W'(1));
    exp_q.push_back(DATA_W'(2));
    dn0 = done_cnt;
    pulse_start(2);
    wait_valid(20, n);
    check("post_rst_latency", n + 1, 3);
    wait_done(50);
    check("post_rst_words_left", exp_q.size(), 0);
    check("post_rst_done_pulses", done_cnt - dn0, 1);
    check("post_rst_fifo_level", fifo_level(), 5);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=1 required=0");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 Parameter DATA_W, default 4, FIFO word width.
REQ-002 Parameter LEN_W, default 5, burst length field width; max burst 2**(LEN_W-1) = 16 words.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 burst_len  input  LEN_W  words to drain; sampled with start; 0 treated as 16.
REQ-007 fifo_dout  input  DATA_W  FIFO read data, valid the cycle after a read strobe.
REQ-008 fifo_empty  input  1  FIFO empty flag.
REQ-009 fifo_rd_en  output  1  FIFO read strobe.
REQ-010 m_data  output  DATA_W  downstream data word.
REQ-011 m_valid  output  1  m_data valid.
REQ-012 m_ready  input  1  downstream accepts m_data when high with m_valid.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  one-cycle pulse when burst completes.
REQ-015 m_parity  output  1  even parity of m_data; present only with RD_CTRL_PARITY_EN.

Function
REQ-016 FSM states IDLE, FETCH, WAIT, PRESENT, DONE; state register only.
REQ-017 IDLE: start=1 -> latch len (0 -> 16), clear word count, go FETCH; start=0 -> stay.
REQ-018 FETCH: fifo_rd_en = !fifo_empty (combinational); fifo_empty=0 -> go WAIT; fifo_empty=1 -> stay, no strobe.
REQ-019 fifo_rd_en low in every state except FETCH; never asserted while fifo_empty=1.
REQ-020 WAIT: register fifo_dout into m_data at the clock edge leaving WAIT; set m_valid; go PRESENT.
REQ-021 PRESENT: m_valid=1, m_data stable until handshake; m_valid&&m_ready -> count+1, clear m_valid; count+1==len -> DONE else FETCH.
REQ-022 m_ready while m_valid=0 has no effect.
REQ-023 DONE: done=1 for exactly one cycle, then IDLE; next start accepted only in IDLE.
REQ-024 start in any non-IDLE state ignored; burst_len changes after capture ignored.
REQ-025 Minimum latency: start edge -> m_valid high 3 cycles later with FIFO non-empty and m_ready=1; one word per 3 cycles steady state.
REQ-026 Word count width LEN_W; compare against latched len; no wrap within a burst.
REQ-027 FIFO going empty mid-burst stalls in FETCH indefinitely; no words dropped or duplicated.

Reset
REQ-028 rst=1 forces state IDLE, count 0, len 0 immediately regardless of clk.
REQ-029 Reset values: fifo_rd_en 0, m_data 0, m_valid 0, busy 0, done 0, m_parity 0.
REQ-030 Reset mid-burst abandons the burst; a word already read from the FIFO is discarded.
REQ-031 First start accepted on the first rising edge after rst deasserts.

Configuration
REQ-032 Macro RD_CTRL_PARITY_EN defined: m_parity port exists, registered alongside m_data, = XOR of m_data bits.
REQ-033 Macro RD_CTRL_PARITY_EN undefined: no m_parity port, no parity logic; all other behaviour identical.

Verification
REQ-034 FIFO preloaded 0..15, start with burst_len=4, m_ready=1 -> m_data 0,1,2,3 in order, 4 fifo_rd_en pulses, done one cycle after the 4th handshake.
REQ-035 burst_len=0 with 16 words -> exactly 16 words 0..15 delivered, one done pulse, FIFO empty afterwards.
REQ-036 fifo_empty=1 at start, word 0xA written 5 cycles later -> fifo_rd_en stays 0 while empty, m_data=0xA delivered once.
REQ-037 m_ready held 0 for 6 cycles while m_valid=1 -> m_data unchanged, no further fifo_rd_en until handshake.
REQ-038 rst asserted in PRESENT of a burst_len=8 burst -> all outputs 0 asynchronously, busy 0, new start after release runs a fresh burst.
REQ-039 With RD_CTRL_PARITY_EN, m_data=4'b0111 -> m_parity=1; m_data=4'b0101 -> m_parity=0.
